// File: rtl/prog_fetch16.sv
// Instruction fetch unit: a small loadable program memory plus an IDLE/RUN/DONE sequencer
// that presents one 16-bit word per consume (irie) to a core and stops on HALT or last address.
module prog_fetch16 #(
    parameter int unsigned ADDR_W  = 4,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic              start,
    input  logic              irie,
    output logic [15:0]       inst,
    output logic [ADDR_W-1:0] pc,
    output logic              running,
    output logic              done,
    output logic [7:0]        icnt,
    output logic              wr_err
);

    localparam int unsigned       Depth = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PcMax = '1;
    localparam logic [ADDR_W-1:0] PcOne = ADDR_W'(1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        icnt_q, icnt_d;
    logic              wr_err_q;
    logic [15:0]       mem [Depth];
    logic              load_ok;
    logic              is_halt;

    assign load_ok = (state_q == StIdle) || (state_q == StDone);
    assign inst    = (state_q == StRun) ? mem[pc_q] : 16'h0000;
    assign is_halt = (inst[15:10] == HALT_OP);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        icnt_d  = icnt_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    pc_d    = '0;
                    icnt_d  = '0;
                end
            end
            StRun: begin
                if (irie) begin
                    if (icnt_q != 8'hFF) icnt_d = icnt_q + 8'd1;
                    // pc freezes on the final consume so done reports the last address
                    if (is_halt || (pc_q == PcMax)) state_d = StDone;
                    else pc_d = pc_q + PcOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            icnt_q   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            icnt_q   <= icnt_d;
            wr_err_q <= wr_en && !load_ok;
        end
    end

    // Memory has no reset so the program survives an abort.
    always_ff @(posedge clk) begin
        if (!rst && wr_en && load_ok) mem[wr_addr] <= wr_data;
    end

    assign pc      = pc_q;
    assign running = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign icnt    = icnt_q;
    assign wr_err  = wr_err_q;

endmodule

// File: doc/prog_fetch16.md
PROG_FETCH16 -- requirements
Module: prog_fetch16

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, program-memory address width; depth = 2^ADDR_W words of 16 bits.
REQ-002 SHALL have parameter HALT_OP, default 6'b111111, opcode field inst[15:10] that terminates a run.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  program-load write strobe.
REQ-006 SHALL have port wr_addr  input  ADDR_W  program-load word address.
REQ-007 SHALL have port wr_data  input  16  program-load instruction word.
REQ-008 SHALL have port start  input  1  begin execution from address 0.
REQ-009 SHALL have port irie  input  1  core IR load enable; the core captures inst on any posedge where irie=1.
REQ-010 SHALL have port inst  output  16  instruction presented to the core.
REQ-011 SHALL have port pc  output  ADDR_W  address of the instruction currently presented.
REQ-012 SHALL have port running  output  1  high in state RUN.
REQ-013 SHALL have port done  output  1  high in state DONE.
REQ-014 SHALL have port icnt  output  8  count of instructions consumed by the core in the current run.
REQ-015 SHALL have port wr_err  output  1  registered one-cycle pulse flagging a write attempted outside IDLE/DONE.

Function
REQ-016 SHALL implement states IDLE (2'b00), RUN (2'b01), DONE (2'b10); 2'b11 SHALL go to IDLE on the next edge.
REQ-017 IDLE: SHALL go to RUN when start=1; otherwise stay.
REQ-018 RUN: on an edge with irie=1, SHALL go to DONE if inst[15:10]==HALT_OP or pc==2^ADDR_W-1; otherwise stay.
REQ-019 DONE: SHALL go to RUN when start=1; otherwise stay.
REQ-020 On entry to RUN from IDLE or DONE, SHALL set pc=0 and icnt=0.
REQ-021 In RUN, on each edge with irie=1 and no transition to DONE, SHALL increment pc by 1; with irie=0, pc SHALL hold.
REQ-022 On the edge that goes RUN->DONE, pc SHALL hold its value, so done reports the address of the last instruction consumed.
REQ-023 inst SHALL be combinational mem[pc] in RUN and 16'h0000 in IDLE and DONE; there is zero latency from a pc change to inst.
REQ-024 icnt SHALL increment on every edge in RUN with irie=1, including the HALT word, and SHALL saturate at 8'hFF.
REQ-025 Writes SHALL be accepted only in IDLE or DONE: mem[wr_addr] <= wr_data on the edge with wr_en=1.
REQ-026 wr_en=1 in RUN SHALL leave memory unchanged and set wr_err=1 for exactly the following cycle.
REQ-027 A write and start on the same edge in IDLE/DONE SHALL both take effect; the written word SHALL be visible at the next edge, including a write to address 0.
REQ-028 start while in RUN SHALL be ignored.
REQ-029 HALT detection SHALL use only the word presented at an edge where irie=1; a HALT word that is never consumed SHALL have no effect.

Reset
REQ-030 On an edge with rst=1, SHALL force state IDLE, pc=0, icnt=0, wr_err=0; outputs then read inst=16'h0000, running=0, done=0.
REQ-031 rst SHALL take priority over start, wr_en and irie on the same edge.
REQ-032 rst mid-run SHALL abort the run immediately.
REQ-033 Program memory SHALL NOT be cleared by rst; contents SHALL be retained.

Verification
REQ-034 Reset then idle: rst=1 for one edge -> inst=0, pc=0, running=0, done=0, icnt=0.
REQ-035 Load and run: write mem[0..2] = 16'h0C12, 16'h2034, 16'hFC00, pulse start, hold irie=1 -> inst sequence 0C12, 2034, FC00, then done=1, pc=2, icnt=3.
REQ-036 Stall: in RUN at pc=1 drop irie for 3 cycles -> pc=1 and inst=mem[1] stable; icnt unchanged.
REQ-037 Full sweep: load 16 non-HALT words and run with irie=1 -> after the 16th consume, done=1, pc=15, icnt=16, and no wrap to 0.
REQ-038 Illegal write: wr_en=1 to address 3 in RUN -> wr_err=1 for one cycle and mem[3] unchanged on a later run.
REQ-039 Abort: rst asserted at pc=5 in RUN -> IDLE, pc=0; a following start re-runs from 0 using the retained memory.
